// File: rtl/memory_sequencer_if.sv
// memory_sequencer_if: request/response handshake and memory_control wiring
// for memory_sequencer. The sequencer takes the slave modport; the upstream
// requester plus the memory_control side take the master modport.
interface memory_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  // request channel
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_data;
  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_error;
  logic                  rsp_mismatch;
  // memory_control side
  logic                  mem_unlock;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_buffer;
  logic                  mem_ready;
  // status
  logic                  busy;

  modport master (
    output req_valid, req_address, req_data, rsp_ready, mem_buffer, mem_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_error, rsp_mismatch,
           mem_unlock, mem_address, mem_data, busy
  );

  modport slave (
    input  req_valid, req_address, req_data, rsp_ready, mem_buffer, mem_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error, rsp_mismatch,
           mem_unlock, mem_address, mem_data, busy
  );
endinterface

// File: rtl/memory_sequencer.sv
// memory_sequencer: command front-end for memory_control. Accepts one
// write-and-readback request per handshake, drives unlock/address/data,
// follows the mem_ready low->high sequence, captures the readback and returns
// it on the response channel. A watchdog aborts a transaction that spends
// TIMEOUT_CYCLES cycles in ARM+WAIT without completing.
// Optional feature: define MEMSEQ_VERIFY_EN to flag readback != written word
// on rsp_mismatch; otherwise rsp_mismatch is tied 0.
module memory_sequencer #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  memory_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // last watchdog value before abort; TIMEOUT_CYCLES is limited to 2..255
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] watchdog;

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      watchdog         <= 8'd0;
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_error    <= 1'b0;
      bus.rsp_mismatch <= 1'b0;
      bus.mem_unlock   <= 1'b0;
      bus.mem_address  <= '0;
      bus.mem_data     <= '0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.mem_address <= bus.req_address;
            bus.mem_data    <= bus.req_data;
            bus.mem_unlock  <= 1'b1;
            bus.req_ready   <= 1'b0;
            bus.busy        <= 1'b1;
            watchdog        <= 8'd0;
            state           <= ARM;
          end else begin
            bus.req_ready   <= 1'b1;
            bus.busy        <= 1'b0;
          end
        end

        ARM: begin
          // controller acknowledges the unlock by dropping mem_ready
          if (!bus.mem_ready) begin
            watchdog <= watchdog + 8'd1;
            state    <= WAIT;
          end else if (watchdog == WD_LAST) begin
            bus.mem_unlock   <= 1'b0;
            bus.rsp_error    <= 1'b1;
            bus.rsp_data     <= '0;
            bus.rsp_mismatch <= 1'b0;
            bus.rsp_valid    <= 1'b1;
            state            <= RESP;
          end else begin
            watchdog <= watchdog + 8'd1;
          end
        end

        WAIT: begin
          // mem_ready returning high means the readback is in mem_buffer
          if (bus.mem_ready) begin
            bus.rsp_data   <= bus.mem_buffer;
            bus.rsp_error  <= 1'b0;
            bus.mem_unlock <= 1'b0;
            bus.rsp_valid  <= 1'b1;
`ifdef MEMSEQ_VERIFY_EN
            bus.rsp_mismatch <= (bus.mem_buffer != bus.mem_data);
`else
            bus.rsp_mismatch <= 1'b0;
`endif
            state <= RESP;
          end else if (watchdog == WD_LAST) begin
            bus.mem_unlock   <= 1'b0;
            bus.rsp_error    <= 1'b1;
            bus.rsp_data     <= '0;
            bus.rsp_mismatch <= 1'b0;
            bus.rsp_valid    <= 1'b1;
            state            <= RESP;
          end else begin
            watchdog <= watchdog + 8'd1;
          end
        end

        RESP: begin
          // response held stable until consumed; rsp_data keeps its value
          if (bus.rsp_ready) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_error    <= 1'b0;
            bus.rsp_mismatch <= 1'b0;
            bus.req_ready    <= 1'b1;
            bus.busy         <= 1'b0;
            state            <= IDLE;
          end else begin
            bus.rsp_valid    <= 1'b1;
          end
        end

        default: begin
          state            <= IDLE;
          watchdog         <= 8'd0;
          bus.req_ready    <= 1'b1;
          bus.rsp_valid    <= 1'b0;
          bus.rsp_error    <= 1'b0;
          bus.rsp_mismatch <= 1'b0;
          bus.mem_unlock   <= 1'b0;
          bus.busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// tb_memory_sequencer: randomized bench for memory_sequencer with a
// behavioural memory_control model and a transaction-level reference.
module tb_memory_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  memory_sequencer_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus ();

  memory_sequencer #(
    .ADDR_WIDTH(10), .DATA_WIDTH(16), .TIMEOUT_CYCLES(32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_acc = -100;

  // memory_control model controls
  bit stuck   = 1'b0;
  bit corrupt = 1'b0;
  int mcnt    = 0;
  logic [15:0] mem [0:1023];

  always @(posedge clock) cyc = cyc + 1;

  // Behavioural memory_control: ready drops after unlock, write, ready returns with readback
  always @(negedge clock) begin
    if (stuck) begin
      bus.mem_ready  = 1'b1;
      bus.mem_buffer = 16'($urandom);
    end else if (bus.mem_unlock === 1'b1) begin
      mcnt = mcnt + 1;
      if (mcnt == 2)
        mem[bus.mem_address] = corrupt ? (bus.mem_data ^ 16'h0001) : bus.mem_data;
      bus.mem_ready  = !(mcnt >= 2 && mcnt < 10);
      bus.mem_buffer = (mcnt >= 10) ? mem[bus.mem_address] : 16'($urandom);
    end else begin
      mcnt = 0;
      bus.mem_ready  = 1'b1;
      bus.mem_buffer = 16'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass = n_pass + 1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},    32'(bus.req_ready),    32'd1);
    check({tag, "_rsp_valid"},    32'(bus.rsp_valid),    32'd0);
    check({tag, "_rsp_data"},     32'(bus.rsp_data),     32'd0);
    check({tag, "_rsp_error"},    32'(bus.rsp_error),    32'd0);
    check({tag, "_rsp_mismatch"}, 32'(bus.rsp_mismatch), 32'd0);
    check({tag, "_mem_unlock"},   32'(bus.mem_unlock),   32'd0);
    check({tag, "_mem_address"},  32'(bus.mem_address),  32'd0);
    check({tag, "_mem_data"},     32'(bus.mem_data),     32'd0);
    check({tag, "_busy"},         32'(bus.busy),         32'd0);
  endtask

  // One transaction; called on a negedge with the sequencer idle, returns on a negedge.
  task automatic run_txn(input logic [9:0] a, input logic [15:0] d,
                         input bit stk, input bit cor, input int hold);
    int k;
    int unl;
    int exp_k;
    logic [15:0] exp_data;
    logic        exp_err;
    logic        exp_mis;
    int acc;

    // transaction-level expectations
    exp_k    = stk ? 32 : 10;
    exp_err  = stk;
    exp_data = stk ? 16'h0000 : (cor ? (d ^ 16'h0001) : d);
`ifdef MEMSEQ_VERIFY_EN
    exp_mis  = cor && !stk;
`else
    exp_mis  = 1'b0;
`endif

    stuck   = stk;
    corrupt = cor;
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid   = 1'b1;
    bus.req_address = a;
    bus.req_data    = d;
    @(posedge clock);
    acc = cyc;
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("acc_busy",      32'(bus.busy),        32'd1);
    check("acc_req_ready", 32'(bus.req_ready),   32'd0);
    check("acc_mem_addr",  32'(bus.mem_address), 32'(a));
    check("acc_mem_data",  32'(bus.mem_data),    32'(d));
    check("acc_gap_ge11",  32'((acc - last_acc) >= 11), 32'd1);
    last_acc = acc;

    k   = 0;
    unl = 32'(bus.mem_unlock);
    while (k < 60) begin
      @(negedge clock);
      k = k + 1;
      if (bus.rsp_valid === 1'b1) break;
      if (bus.mem_unlock === 1'b1) unl = unl + 1;
    end
    check("rsp_latency",   32'(k),                exp_k);
    check("unlock_cycles", 32'(unl),              exp_k);
    check("rsp_data",      32'(bus.rsp_data),     32'(exp_data));
    check("rsp_error",     32'(bus.rsp_error),    32'(exp_err));
    check("rsp_mismatch",  32'(bus.rsp_mismatch), 32'(exp_mis));
    check("rsp_unlock",    32'(bus.mem_unlock),   32'd0);

    // back-pressure with a competing request that must be ignored
    if (hold > 0) begin
      bus.req_valid   = 1'b1;
      bus.req_address = ~a;
      bus.req_data    = ~d;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check("hold_rsp_valid", 32'(bus.rsp_valid),   32'd1);
        check("hold_rsp_data",  32'(bus.rsp_data),    32'(exp_data));
        check("hold_req_ready", 32'(bus.req_ready),   32'd0);
        check("hold_mem_addr",  32'(bus.mem_address), 32'(a));
      end
      bus.req_valid = 1'b0;
    end

    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_busy",      32'(bus.busy),      32'd0);
    check("done_req_ready", 32'(bus.req_ready), 32'd1);
    check("done_rsp_error", 32'(bus.rsp_error), 32'd0);
    check("done_rsp_keep",  32'(bus.rsp_data),  32'(exp_data));
    stuck   = 1'b0;
    corrupt = 1'b0;
  endtask

  initial begin
    int seen;
    bus.req_valid   = 1'b0;
    bus.req_address = 10'd0;
    bus.req_data    = 16'd0;
    bus.rsp_ready   = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clock);
    check_reset_values("post_reset");

    // directed scenarios
    run_txn(10'h005, 16'hBEEF, 1'b0, 1'b0, 0);
    run_txn(10'h000, 16'h1234, 1'b0, 1'b0, 0);
    run_txn(10'h3FF, 16'hA5A5, 1'b0, 1'b0, 0);
    run_txn(10'h0AA, 16'h5A5A, 1'b0, 1'b0, 20);
    run_txn(10'h123, 16'h0F0F, 1'b1, 1'b0, 2);
    run_txn(10'h005, 16'hBEEF, 1'b0, 1'b1, 0);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      run_txn(10'($urandom), 16'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 4)));
    end

    // reset in the middle of a transaction
    bus.req_valid   = 1'b1;
    bus.req_address = 10'h155;
    bus.req_data    = 16'hC0DE;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1 check_reset_values("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.rsp_valid === 1'b1) seen = seen + 1;
    end
    bus.rsp_ready = 1'b0;
    check("no_rsp_after_reset", 32'(seen), 32'd0);
    check_reset_values("after_reset_idle");

    // recovery after reset
    last_acc = -100;
    run_txn(10'h2C3, 16'h7E81, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
